// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch history table access path.
//   IDX_W_DEFAULT : default table index width
//   IDX_W_MAX     : widest index a 32-bit word-aligned PC can supply
//   bht_upd_t     : one queued resolution {idx, taken, correct}
//   pc_to_idx     : word-aligned PC to table index, masked to a given width
package bht_pkg;

  localparam int IDX_W_DEFAULT = 10;
  localparam int IDX_W_MAX     = 30;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] idx;
    logic                 taken;
    logic                 correct;
  } bht_upd_t;

  // Drops the two byte-offset bits and keeps the low w bits of the word address.
  function automatic logic [IDX_W_MAX-1:0] pc_to_idx(input logic [31:0] pc,
                                                     input int unsigned w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return IDX_W_MAX'((pc >> 2) & mask);
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Synchronous FIFO holding branch resolutions until the table can take them.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (pointers only)
//   push, din    : write an entry (ignored while full)
//   pop, dout    : dout is the head entry; pop removes it (ignored while empty)
//   full, empty  : occupancy flags derived from the registered pointers
module bht_upd_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; stale slots are never read while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/bht_ctrl.sv
// Access scheduler for the branch history table. Shares the table's single
// access per cycle between fetch lookups and queued execute-stage updates.
// Lookups win unless the update queue is full or its head has waited
// STARVE_LIMIT cycles, in which case the update is forced through.
// Optional feature macro: BHT_CTRL_PERF_EN enables the performance counters;
// without it perf_* are tied to 0.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   lookup_req/pc/ready, pred_taken : fetch lookup handshake, 0-latency result
//   upd_valid/pc/taken/correct/ready: execute resolution push handshake
//   bht_read, bht_r_idx, bht_prediction                : table read port
//   bht_load, bht_w_idx, bht_taken, bht_correct        : table update port
//   perf_lookups, perf_updates, perf_mispred           : saturating counters
module bht_ctrl
  import bht_pkg::*;
#(
  parameter int IDX_W        = IDX_W_DEFAULT,
  parameter int QDEPTH       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_req,
  input  logic [31:0]      lookup_pc,
  output logic             lookup_ready,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic             upd_correct,
  output logic             upd_ready,
  output logic             bht_read,
  output logic [IDX_W-1:0] bht_r_idx,
  input  logic             bht_prediction,
  output logic             bht_load,
  output logic [IDX_W-1:0] bht_w_idx,
  output logic             bht_taken,
  output logic             bht_correct,
  output logic [31:0]      perf_lookups,
  output logic [31:0]      perf_updates,
  output logic [31:0]      perf_mispred
);

  localparam int WCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(STARVE_LIMIT);

  bht_upd_t         new_ent;
  bht_upd_t         head;
  logic             full;
  logic             empty;
  logic             push;
  logic             drain;
  logic             force_drain;
  logic             forced;
  logic [IDX_W-1:0] lk_idx;
  logic [WCNT_W-1:0] wait_cnt;

  assign lk_idx = IDX_W'(pc_to_idx(lookup_pc, IDX_W));

  always_comb begin
    new_ent         = '0;
    new_ent.idx     = pc_to_idx(upd_pc, IDX_W);
    new_ent.taken   = upd_taken;
    new_ent.correct = upd_correct;
  end

  bht_upd_fifo #(
    .W     ($bits(bht_upd_t)),
    .DEPTH (QDEPTH)
  ) u_upd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (new_ent),
    .pop   (drain),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Arbiter: everything below depends on registered state and lookup_req only,
  // never on upd_valid, so the ready signals have no path from the push side.
  always_comb begin
    force_drain  = full || (wait_cnt >= WAIT_MAX);
    drain        = !empty && (force_drain || !lookup_req);
    // An unforced drain implies lookup_req=0, so only a forced one blocks fetch.
    forced       = drain && force_drain;
    upd_ready    = !full;
    push         = upd_valid && !full;
    lookup_ready = !forced;
    bht_read     = lookup_req && !forced;
    bht_r_idx    = bht_read ? lk_idx : '0;
    pred_taken   = bht_read ? bht_prediction : 1'b0;
    bht_load     = drain;
    bht_w_idx    = drain ? IDX_W'(head.idx) : '0;
    bht_taken    = drain && head.taken;
    bht_correct  = drain && head.correct;
  end

  // Age of the queue head in cycles; saturates so the force condition holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (empty || drain) begin
      wait_cnt <= '0;
    end else if (wait_cnt < WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef BHT_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lookups <= '0;
      perf_updates <= '0;
      perf_mispred <= '0;
    end else begin
      if (bht_read && (perf_lookups != '1))              perf_lookups <= perf_lookups + 1'b1;
      if (drain && (perf_updates != '1))                 perf_updates <= perf_updates + 1'b1;
      if (drain && !head.correct && (perf_mispred != '1)) perf_mispred <= perf_mispred + 1'b1;
    end
  end
`else
  assign perf_lookups = '0;
  assign perf_updates = '0;
  assign perf_mispred = '0;
`endif

endmodule
